ofm_writeback: RTL and testbench

- Write-back end of the conv datapath. Consumes the 16-lane OFM byte stream that Sub_top_CONV qualifies with valid == 16'hFFFF.
- Packs each 16-byte beat into four 32-bit words and drives the word-addressed BRAM write port (addr / data / wr_en) using the same byte order the IFM loader uses.
- The OFM of one layer lands directly as the HWC-ordered IFM image of the next layer.

---
 rtl/ofm_wb_pkg.sv | 31 +++
 rtl/ofm_wb_fifo.sv | 66 ++++++
 rtl/ofm_writeback.sv | 158 +++++++++++++++
 tb/tb_ofm_writeback.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_wb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ofm_wb_pkg                                                             |
// | Shared types, constants and byte-packing helper for OFM write-back.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package ofm_wb_pkg;

    localparam int LANES = 16;
    localparam logic [LANES-1:0] ALL_VALID = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word w carries lanes 4w..4w+3, lowest lane in the most significant byte,
    // matching the byte order the IFM loader expects.
    function automatic logic [31:0] pack_word(input logic [8*LANES-1:0] beat,
                                              input logic [1:0]         w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = beat[32*int'(w) + 8*i +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_wb_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ofm_wb_fifo                                                            |
// | Small synchronous FIFO; push and pop may occur in the same cycle.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module ofm_wb_fifo
    import ofm_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8*LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofm_writeback.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ofm_writeback                                                          |
// | Buffers 16-byte OFM beats and writes them as HWC-ordered 32-bit words. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module ofm_writeback #(
    parameter int LANES      = 16,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          cfg_ofm_w,
    input  logic [7:0]          cfg_ofm_c,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LANES-1:0]    valid,
    input  logic [8*LANES-1:0]  ofm_bus,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   addr,
    output logic [31:0]         data_out,
    output logic                busy,
    output logic                done,
    output logic                err_overflow,
    output logic                err_partial
);
    import ofm_wb_pkg::*;

    state_t              r_state;
    logic [7:0]          r_cfg_w;
    logic [5:0]          r_cfg_c4;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_pix_base;
    logic [ADDR_W-1:0]   r_tile_off;
    logic [7:0]          r_x;
    logic [7:0]          r_y;
    logic [3:0]          r_tile;
    logic [1:0]          r_word;
    logic                r_busy;
    logic                r_done;
    logic                r_err_ovf;
    logic                r_err_part;

    logic [8*LANES-1:0]  w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_run, w_wr, w_pop, w_push, w_drop, w_partial, w_start;
    logic                w_full_beat, w_last_pix, w_last_tile;
    logic                w_unused_cfg;

    assign w_unused_cfg = &{1'b0, cfg_ofm_c[1:0]};

    assign w_run       = (r_state == RUN);
    assign w_start     = start && (r_state != RUN);
    assign w_full_beat = (valid == ALL_VALID);
    assign w_wr        = w_run && !w_fifo_empty;
    assign w_pop       = w_wr && (r_word == 2'd3);
    assign w_push      = w_run && w_full_beat && (!w_fifo_full || w_pop);
    assign w_drop      = w_run && w_full_beat && w_fifo_full && !w_pop;
    assign w_partial   = w_run && (valid != '0) && !w_full_beat;
    assign w_last_pix  = (r_x == r_cfg_w - 8'd1) && (r_y == r_cfg_w - 8'd1);
    assign w_last_tile = (r_tile == r_cfg_c4[5:2] - 4'd1);

    ofm_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8*LANES)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (ofm_bus),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign wr_en        = w_wr;
    assign addr         = w_wr ? (r_pix_base + r_tile_off + ADDR_W'(r_word)) : '0;
    assign data_out     = w_wr ? pack_word(w_head, r_word) : 32'd0;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_overflow = r_err_ovf;
    assign err_partial  = r_err_part;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cfg_w    <= '0;
            r_cfg_c4   <= '0;
            r_base     <= '0;
            r_pix_base <= '0;
            r_tile_off <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_tile     <= '0;
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_part <= 1'b0;
        end else begin
            if (w_drop)    r_err_ovf  <= 1'b1;
            if (w_partial) r_err_part <= 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_cfg_w    <= cfg_ofm_w;
                        r_cfg_c4   <= cfg_ofm_c[7:2];
                        r_base     <= cfg_base;
                        r_pix_base <= cfg_base;
                        r_tile_off <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_tile     <= '0;
                        r_word     <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err_ovf  <= 1'b0;
                        r_err_part <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_wr) r_word <= r_word + 2'd1;
                    // Address walk advances once per fully written beat.
                    if (w_pop) begin
                        if (w_last_pix) begin
                            r_pix_base <= r_base;
                            r_tile_off <= r_tile_off + ADDR_W'(4);
                            r_x        <= '0;
                            r_y        <= '0;
                            r_tile     <= r_tile + 4'd1;
                            if (w_last_tile) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_pix_base <= r_pix_base + ADDR_W'(r_cfg_c4);
                            if (r_x == r_cfg_w - 8'd1) begin
                                r_x <= '0;
                                r_y <= r_y + 8'd1;
                            end else begin
                                r_x <= r_x + 8'd1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofm_writeback.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ofm_writeback                                                       |
// | Randomized scoreboard bench for the OFM write-back block.              |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_ofm_writeback;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   cfg_ofm_w = '0;
    logic [7:0]   cfg_ofm_c = '0;
    logic [19:0]  cfg_base = '0;
    logic [15:0]  valid = '0;
    logic [127:0] ofm_bus = '0;
    logic         wr_en;
    logic [19:0]  addr;
    logic [31:0]  data_out;
    logic         busy;
    logic         done;
    logic         err_overflow;
    logic         err_partial;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    int m_w, m_c, m_base, m_idx;

    always #5 clk = ~clk;

    ofm_writeback #(
        .LANES      (16),
        .ADDR_W     (20),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_ofm_w    (cfg_ofm_w),
        .cfg_ofm_c    (cfg_ofm_c),
        .cfg_base     (cfg_base),
        .valid        (valid),
        .ofm_bus      (ofm_bus),
        .wr_en        (wr_en),
        .addr         (addr),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_partial  (err_partial)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write_addr", {12'd0, addr} | 32'h8000_0000, 32'h0);
            end else begin
                logic [19:0] a;
                logic [31:0] d;
                a = exp_addr_q.pop_front();
                d = exp_data_q.pop_front();
                check("wr_addr", {12'd0, addr}, {12'd0, a});
                check("wr_data", data_out, d);
            end
        end
    end

    // Reference: beat i of a layer is tile i/(W*W), pixel i%(W*W) in HWC order.
    task automatic expect_beat(input logic [127:0] bus);
        int pix, t, p;
        logic [7:0] b [4];
        pix = m_w * m_w;
        t   = m_idx / pix;
        p   = m_idx % pix;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 4; j++) b[j] = bus[8*(4*w+j) +: 8];
            exp_addr_q.push_back(20'(m_base + p*(m_c/4) + t*4 + w));
            exp_data_q.push_back({b[0], b[1], b[2], b[3]});
        end
        m_idx++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [127:0] bus, input logic [15:0] v);
        valid   = v;
        ofm_bus = bus;
        @(posedge clk);
        #1;
        valid = '0;
    endtask

    task automatic do_start(input int w, input int c, input int base);
        cfg_ofm_w = 8'(w);
        cfg_ofm_c = 8'(c);
        cfg_base  = 20'(base);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_w = w; m_c = c; m_base = base; m_idx = 0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_flags", {err_overflow, err_partial}, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_bus();
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_addr_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, (k < 300) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic finish_layer(input string name, input logic exp_done);
        wait_drain(name);
        check({name, "_done"}, done, 32'(exp_done));
        check({name, "_busy"}, busy, 32'(!exp_done));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] bus;

        valid   = 16'hFFFF;
        ofm_bus = rand_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err_overflow", err_overflow, 0);
        check("reset_err_partial", err_partial, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = '0;
        idle(2);

        // Single beat with lane k = k+1.
        do_start(1, 16, 'h100);
        for (int k = 0; k < 16; k++) bus[8*k +: 8] = 8'(k + 1);
        expect_beat(bus);
        send_beat(bus, 16'hFFFF);
        finish_layer("single", 1'b1);

        // Layout: two tiles of a 2x2 image, beats 6 cycles apart.
        do_start(2, 32, 0);
        for (int i = 0; i < 8; i++) begin
            bus = rand_bus();
            expect_beat(bus);
            send_beat(bus, 16'hFFFF);
            idle(5);
        end
        finish_layer("layout", 1'b1);

        // Beats arriving in DONE are ignored.
        send_beat(rand_bus(), 16'hFFFF);
        idle(6);
        check("done_ignores_beats", done, 1);

        // Random layers with random gaps that never exceed the drain rate.
        for (int r = 0; r < 4; r++) begin
            int w, c, n;
            w = int'($urandom_range(1, 3));
            c = 16 * int'($urandom_range(1, 4));
            n = w * w * c / 16;
            do_start(w, c, int'($urandom_range(0, 'hF0000)));
            for (int i = 0; i < n; i++) begin
                bus = rand_bus();
                expect_beat(bus);
                send_beat(bus, 16'hFFFF);
                idle(int'($urandom_range(3, 6)));
            end
            finish_layer("random", 1'b1);
        end

        // Push into a full FIFO in the same cycle as a pop is accepted.
        do_start(1, 48, 'h300);
        for (int i = 0; i < 2; i++) begin
            bus = rand_bus();
            expect_beat(bus);
            send_beat(bus, 16'hFFFF);
        end
        idle(2);
        bus = rand_bus();
        expect_beat(bus);
        send_beat(bus, 16'hFFFF);
        finish_layer("full_with_pop", 1'b1);
        check("full_with_pop_no_ovf", err_overflow, 0);

        // Back-to-back: third beat overflows a depth-2 FIFO.
        do_start(2, 16, 0);
        for (int i = 0; i < 2; i++) begin
            bus = rand_bus();
            expect_beat(bus);
            send_beat(bus, 16'hFFFF);
        end
        valid   = 16'hFFFF;
        ofm_bus = rand_bus();
        @(negedge clk);
        check("ovf_before_drop", err_overflow, 0);
        @(posedge clk);
        #1;
        valid = '0;
        @(negedge clk);
        check("ovf_after_drop", err_overflow, 1);
        @(posedge clk);
        #1;
        finish_layer("overflow", 1'b0);
        idle(6);
        check("ovf_sticky", err_overflow, 1);

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Partial valid is discarded and flagged; the next full beat still lands at base.
        do_start(1, 16, 'h40);
        send_beat(rand_bus(), 16'h00FF);
        @(negedge clk);
        check("partial_flag", err_partial, 1);
        check("partial_no_write", wr_en, 0);
        @(posedge clk);
        #1;
        bus = rand_bus();
        expect_beat(bus);
        send_beat(bus, 16'hFFFF);
        finish_layer("partial", 1'b1);
        check("partial_sticky", err_partial, 1);
        check("partial_no_ovf", err_overflow, 0);

        // Abort: reset after word 1 of a beat.
        do_start(2, 16, 'h200);
        bus = rand_bus();
        expect_beat(bus);
        void'(exp_addr_q.pop_back());
        void'(exp_addr_q.pop_back());
        void'(exp_data_q.pop_back());
        void'(exp_data_q.pop_back());
        send_beat(bus, 16'hFFFF);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        check("abort_words_seen", exp_addr_q.size(), 0);
        do_start(2, 16, 'h200);
        bus = rand_bus();
        expect_beat(bus);
        send_beat(bus, 16'hFFFF);
        finish_layer("after_abort", 1'b0);
        check("after_abort_flags", {err_overflow, err_partial}, 0);

        idle(4);
        check("leftover_expected", exp_addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
